// File: rtl/bpf_bank_tdm.sv
// Time-multiplexed band-pass bank: NCH channels of NSEC Direct Form I biquads sharing one multiplier.
// Per-channel windowed power accumulation is compiled in only when BPF_POWER_EN is defined.
module bpf_bank_tdm #(
    parameter int NCH  = 6,
    parameter int NSEC = 2,
    parameter int WIN  = 9600,
    parameter int PSH  = 26,
    parameter int PW   = 11,
    localparam int NCOEF = NCH * NSEC * 5,
    localparam int AW    = (NCOEF > 1) ? $clog2(NCOEF) : 1,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic signed [15:0]  iAud,
    input  logic                coef_we,
    input  logic [AW-1:0]       coef_addr,
    input  logic signed [26:0]  coef_data,
    output logic                coef_ready,
    output logic                out_valid,
    output logic [CHW-1:0]      out_ch,
    output logic signed [15:0]  oAud,
    output logic                power_valid,
    output logic [NCH*PW-1:0]   power,
    output logic                busy,
    output logic                overrun
);
    localparam int NHIST = NCH * NSEC;
    localparam int HW    = (NHIST > 1) ? $clog2(NHIST) : 1;
    localparam int SECW  = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int WCW   = (WIN > 1) ? $clog2(WIN) : 1;

    typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

    function automatic logic signed [26:0] sat27(input logic signed [53:0] a);
        logic signed [30:0] sh;
        sh = a[53:23];
        if (sh[30:26] == {5{sh[26]}}) sat27 = sh[26:0];
        else if (sh[30]) sat27 = {1'b1, 26'd0};
        else sat27 = {1'b0, {26{1'b1}}};
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [26:0] y);
        if (y[26:23] == {4{y[23]}}) sat16 = y[23:8];
        else if (y[26]) sat16 = 16'sh8000;
        else sat16 = 16'sh7fff;
    endfunction

`ifdef BPF_POWER_EN
    // Magnitude with the most negative code folded onto the largest positive one.
    function automatic logic [26:0] abs27(input logic signed [26:0] y);
        if (y == {1'b1, 26'd0}) abs27 = {1'b0, {26{1'b1}}};
        else if (y[26]) abs27 = -y;
        else abs27 = y;
    endfunction

    function automatic logic [PW-1:0] pslice(input logic [39:0] a);
        if ((a >> (PSH + PW)) != 40'd0) pslice = '1;
        else pslice = a[PSH +: PW];
    endfunction
`endif

    state_t                 state_q, state_d;
    logic [2:0]             k_q, k_d;
    logic [SECW-1:0]        sec_q, sec_d;
    logic [CHW-1:0]         ch_q, ch_d;
    logic signed [26:0]     x_in_q, x_in_d;
    logic signed [26:0]     y_q, y_d;
    logic signed [53:0]     acc_q, acc_d;
    logic signed [26:0]     x1_q [NHIST];
    logic signed [26:0]     x1_d [NHIST];
    logic signed [26:0]     x2_q [NHIST];
    logic signed [26:0]     x2_d [NHIST];
    logic signed [26:0]     y1_q [NHIST];
    logic signed [26:0]     y1_d [NHIST];
    logic signed [26:0]     y2_q [NHIST];
    logic signed [26:0]     y2_d [NHIST];
    logic signed [26:0]     coef_q [NCOEF];
    logic signed [26:0]     coef_d [NCOEF];
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   out_valid_q, out_valid_d;
    logic [CHW-1:0]         out_ch_q, out_ch_d;
    logic signed [15:0]     oaud_q, oaud_d;
    logic                   power_valid_q, power_valid_d;
    logic [NCH*PW-1:0]      power_q, power_d;
`ifdef BPF_POWER_EN
    logic [39:0]            pacc_q [NCH];
    logic [39:0]            pacc_d [NCH];
    logic [WCW-1:0]         win_q, win_d;
    logic [39:0]            pacc_sum_s;
`endif

    logic [AW-1:0]          cidx_s;
    logic [HW-1:0]          hidx_s;
    logic                   last_sec_s, last_ch_s;
    logic signed [26:0]     x_cur_s, mul_a_s, mul_b_s, y_new_s;
    logic signed [53:0]     prod_s, term_s;

    // Address decode and operand selection for the shared multiplier.
    always_comb begin
        cidx_s     = AW'((int'(ch_q) * NSEC + int'(sec_q)) * 5 + int'(k_q));
        hidx_s     = HW'(int'(ch_q) * NSEC + int'(sec_q));
        last_sec_s = (int'(sec_q) == NSEC - 1);
        last_ch_s  = (int'(ch_q) == NCH - 1);
        if (sec_q == '0) x_cur_s = x_in_q;
        else x_cur_s = y_q;
        mul_a_s = coef_q[cidx_s];
        case (k_q)
            3'd0:    mul_b_s = x_cur_s;
            3'd1:    mul_b_s = x1_q[hidx_s];
            3'd2:    mul_b_s = x2_q[hidx_s];
            3'd3:    mul_b_s = y1_q[hidx_s];
            3'd4:    mul_b_s = y2_q[hidx_s];
            default: mul_b_s = '0;
        endcase
        prod_s = mul_a_s * mul_b_s;
        // Feedback taps are subtracted since a0 is implicitly +1.0.
        if (k_q >= 3'd3) term_s = -prod_s;
        else term_s = prod_s;
        y_new_s = sat27(acc_q);
`ifdef BPF_POWER_EN
        pacc_sum_s = pacc_q[ch_q] + {13'd0, abs27(y_q)};
`endif
    end

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        sec_d         = sec_q;
        ch_d          = ch_q;
        x_in_d        = x_in_q;
        y_d           = y_q;
        acc_d         = acc_q;
        x1_d          = x1_q;
        x2_d          = x2_q;
        y1_d          = y1_q;
        y2_d          = y2_q;
        coef_d        = coef_q;
        out_valid_d   = 1'b0;
        out_ch_d      = out_ch_q;
        oaud_d        = oaud_q;
        power_valid_d = 1'b0;
        power_d       = power_q;
`ifdef BPF_POWER_EN
        pacc_d        = pacc_q;
        win_d         = win_q;
`endif

        if (coef_we && !busy_q && (int'(coef_addr) < NCOEF)) coef_d[coef_addr] = coef_data;
        else coef_d = coef_q;

        if (sample_valid && busy_q) overrun_d = 1'b1;
        else overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (sample_valid && enable) begin
                    x_in_d  = {{3{iAud[15]}}, iAud, 8'd0};
                    k_d     = 3'd0;
                    sec_d   = '0;
                    ch_d    = '0;
                    state_d = MAC;
                end else begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                if (k_q == 3'd0) acc_d = term_s;
                else acc_d = acc_q + term_s;
                if (k_q == 3'd4) begin
                    k_d     = 3'd0;
                    state_d = WB;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            WB: begin
                x2_d[hidx_s] = x1_q[hidx_s];
                x1_d[hidx_s] = x_cur_s;
                y2_d[hidx_s] = y1_q[hidx_s];
                y1_d[hidx_s] = y_new_s;
                y_d          = y_new_s;
                if (last_sec_s) begin
                    out_valid_d = 1'b1;
                    out_ch_d    = ch_q;
                    oaud_d      = sat16(y_new_s);
                    state_d     = OUT;
                end else begin
                    sec_d   = sec_q + SECW'(1);
                    state_d = MAC;
                end
            end
            OUT: begin
`ifdef BPF_POWER_EN
                pacc_d[ch_q] = pacc_sum_s;
                if (last_ch_s) begin
                    if (int'(win_q) == WIN - 1) begin
                        for (int c = 0; c < NCH; c++) begin
                            if (c == NCH - 1) power_d[c*PW +: PW] = pslice(pacc_sum_s);
                            else power_d[c*PW +: PW] = pslice(pacc_q[c]);
                            pacc_d[c] = 40'd0;
                        end
                        win_d         = '0;
                        power_valid_d = 1'b1;
                    end else begin
                        win_d = win_q + WCW'(1);
                    end
                end else begin
                    win_d = win_q;
                end
`endif
                if (last_ch_s) begin
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + CHW'(1);
                    sec_d   = '0;
                    k_d     = 3'd0;
                    state_d = MAC;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, history, coefficient and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= 3'd0;
            sec_q         <= '0;
            ch_q          <= '0;
            x_in_q        <= '0;
            y_q           <= '0;
            acc_q         <= '0;
            x1_q          <= '{default: '0};
            x2_q          <= '{default: '0};
            y1_q          <= '{default: '0};
            y2_q          <= '{default: '0};
            coef_q        <= '{default: '0};
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_ch_q      <= '0;
            oaud_q        <= '0;
            power_valid_q <= 1'b0;
            power_q       <= '0;
`ifdef BPF_POWER_EN
            pacc_q        <= '{default: '0};
            win_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            sec_q         <= sec_d;
            ch_q          <= ch_d;
            x_in_q        <= x_in_d;
            y_q           <= y_d;
            acc_q         <= acc_d;
            x1_q          <= x1_d;
            x2_q          <= x2_d;
            y1_q          <= y1_d;
            y2_q          <= y2_d;
            coef_q        <= coef_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            out_valid_q   <= out_valid_d;
            out_ch_q      <= out_ch_d;
            oaud_q        <= oaud_d;
            power_valid_q <= power_valid_d;
            power_q       <= power_d;
`ifdef BPF_POWER_EN
            pacc_q        <= pacc_d;
            win_q         <= win_d;
`endif
        end
    end

    assign coef_ready  = ~busy_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign out_valid   = out_valid_q;
    assign out_ch      = out_ch_q;
    assign oAud        = oaud_q;
    assign power_valid = power_valid_q;
    assign power       = power_q;

endmodule

// File: tb/tb_bpf_bank_tdm.sv
// Directed bench for bpf_bank_tdm with NCH=2, NSEC=2, WIN=4, PSH=8, PW=11.
module tb_bpf_bank_tdm;
    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               sample_valid;
    logic signed [15:0] iAud;
    logic               coef_we;
    logic [4:0]         coef_addr;
    logic signed [26:0] coef_data;
    logic               coef_ready;
    logic               out_valid;
    logic [0:0]         out_ch;
    logic signed [15:0] oAud;
    logic               power_valid;
    logic [21:0]        power;
    logic               busy;
    logic               overrun;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] o0, o1;
    int                 c0, c1, nout, npv, cnt;
    logic               b1, b27, rdy;
    logic [63:0]        exp_pow;
    int                 exp_pv;

    bpf_bank_tdm #(.NCH(2), .NSEC(2), .WIN(4), .PSH(8), .PW(11)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .iAud(iAud), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_ready(coef_ready), .out_valid(out_valid), .out_ch(out_ch), .oAud(oAud),
        .power_valid(power_valid), .power(power), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ca(input int c, input int s, input int k);
        return 5'((c * 2 + s) * 5 + k);
    endfunction

    task automatic write_coef(input logic [4:0] a, input logic signed [26:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic identity_all();
        write_coef(ca(0, 0, 0), 27'sh0800000);
        write_coef(ca(0, 1, 0), 27'sh0800000);
        write_coef(ca(1, 0, 0), 27'sh0800000);
        write_coef(ca(1, 1, 0), 27'sh0800000);
    endtask

    // One full frame from capture (cycle 0) to cycle 27; optional second strobe plus coef write at drop_at.
    task automatic do_frame(input logic signed [15:0] s, input int drop_at,
                            output logic signed [15:0] r0, output logic signed [15:0] r1,
                            output int rc0, output int rc1, output int rn, output int rpv,
                            output logic rb1, output logic rb27, output logic rrdy);
        iAud = s; sample_valid = 1'b1;
        r0 = 16'sd0; r1 = 16'sd0; rc0 = -1; rc1 = -1; rn = 0; rpv = 0;
        rb1 = 1'b0; rb27 = 1'b1; rrdy = 1'b1;
        for (int n = 1; n <= 27; n++) begin
            @(negedge clk);
            sample_valid = 1'b0; coef_we = 1'b0;
            if (out_valid) begin
                rn++;
                if (out_ch == 1'b0) begin r0 = oAud; rc0 = n; end
                else begin r1 = oAud; rc1 = n; end
            end
            if (power_valid) rpv++;
            if (n == 1) rb1 = busy;
            if (n == 27) rb27 = busy;
            if (n == drop_at) begin
                rrdy = coef_ready; sample_valid = 1'b1; coef_we = 1'b1;
                coef_addr = ca(1, 1, 0); coef_data = 27'sd0; iAud = 16'sd123;
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; sample_valid = 1'b0; iAud = 16'sd0;
        coef_we = 1'b0; coef_addr = 5'd0; coef_data = 27'sd0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_oaud", oAud, 0);
        check("rst_overrun", overrun, 0);
        check("rst_pvalid", power_valid, 0);
        check("rst_power", power, 0);
        check("rst_coef_ready", coef_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Pass-through on both channels with exact output timing.
        identity_all();
        do_frame(16'sd1000, 0, o0, o1, c0, c1, nout, npv, b1, b27, rdy);
        check("id_ch0", o0, 1000);
        check("id_ch1", o1, 1000);
        check("id_cyc0", c0, 13);
        check("id_cyc1", c1, 26);
        check("id_nout", nout, 2);
        check("id_busy1", b1, 1);
        check("id_busy27", b27, 0);

        // First-order recursion a1=-0.5 on channel 0.
        pulse_reset();
        identity_all();
        write_coef(ca(0, 0, 3), 27'sh7C00000);
        do_frame(16'sd16384, 0, o0, o1, c0, c1, nout, npv, b1, b27, rdy);
        check("iir_s0_ch0", o0, 16384);
        check("iir_s0_ch1", o1, 16384);
        do_frame(16'sd0, 0, o0, o1, c0, c1, nout, npv, b1, b27, rdy);
        check("iir_s1_ch0", o0, 8192);
        check("iir_s1_ch1", o1, 0);
        do_frame(16'sd0, 0, o0, o1, c0, c1, nout, npv, b1, b27, rdy);
        check("iir_s2_ch0", o0, 4096);

        // Gain ~8 on channel 1: saturation both ways, no wrap.
        write_coef(ca(1, 0, 0), 27'sh3FFFFFF);
        do_frame(16'sd32767, 0, o0, o1, c0, c1, nout, npv, b1, b27, rdy);
        check("sat_pos_ch1", o1, 32767);
        check("sat_pos_ch0", o0, 32767);
        do_frame(-16'sd32768, 0, o0, o1, c0, c1, nout, npv, b1, b27, rdy);
        check("sat_neg_ch1", o1, -32768);
        check("floor_ch0", o0, -15361);

        // Disabled input is ignored.
        enable = 1'b0; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("en_low_busy", busy, 0);
        check("en_low_overrun", overrun, 0);
        enable = 1'b1;

        // Strobe at cycle 5 is dropped, flags overrun, and coef write is refused.
        do_frame(16'sd100, 5, o0, o1, c0, c1, nout, npv, b1, b27, rdy);
        check("ovr_ready5", rdy, 0);
        check("ovr_ch1", o1, 799);
        check("ovr_nout", nout, 2);
        check("ovr_flag", overrun, 1);
        @(negedge clk);
        check("ovr_no_frame_28", busy, 0);
        @(negedge clk);
        check("ovr_no_frame_29", busy, 0);
        do_frame(16'sd100, 0, o0, o1, c0, c1, nout, npv, b1, b27, rdy);
        check("ovr_coef_kept", o1, 799);
        check("ovr_sticky", overrun, 1);

        // Reset at cycle 7 of a frame.
        iAud = 16'sd500; sample_valid = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
        check("mid_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_oaud", oAud, 0);
        check("mid_overrun", overrun, 0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid || busy) cnt++;
        end
        check("mid_quiet", cnt, 0);
        identity_all();
        write_coef(ca(0, 0, 3), 27'sh7C00000);
        do_frame(16'sd16384, 0, o0, o1, c0, c1, nout, npv, b1, b27, rdy);
        check("mid_zero_ch0", o0, 16384);
        check("mid_zero_ch1", o1, 16384);
        do_frame(16'sd0, 0, o0, o1, c0, c1, nout, npv, b1, b27, rdy);
        check("mid_zero_next", o0, 8192);

        // Power window of four frames at constant -256.
`ifdef BPF_POWER_EN
        exp_pow = (64'd1024 << 11) | 64'd1024;
        exp_pv  = 1;
`else
        exp_pow = 64'd0;
        exp_pv  = 0;
`endif
        pulse_reset();
        identity_all();
        for (int f = 1; f <= 4; f++) begin
            do_frame(-16'sd256, 0, o0, o1, c0, c1, nout, npv, b1, b27, rdy);
            check("pw_ch0", o0, -256);
            check("pw_ch1", o1, -256);
            if (f < 4) check("pw_early", npv, 0);
            else check("pw_frame4", npv, exp_pv);
        end
        check("pw_value", power, exp_pow);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
